// File: rtl/alu_rr_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters: accepts one op,
// drives the ALU for ALU_LAT cycles, then returns the captured result tagged with the requester ID.
module alu_rr_arbiter #(
   parameter int WIDTH   = 6,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_flag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] result,
   output logic             flag,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter reaches zero on the cycle whose closing edge samples the ALU result.
   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
   logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             flag_q, flag_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   logic gnt_valid_s;
   logic gnt_id_s;
   logic idle_s;
   logic accept_s;

   // Grant selection: a lone requester always wins, contention goes to the one not served last.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = ~last_q;
      end else if (req0_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b0;
      end else if (req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_id_s    = 1'b0;
      end
   end

   assign idle_s     = (state_q == IDLE) && !reset;
   assign req0_ready = idle_s && gnt_valid_s && !gnt_id_s;
   assign req1_ready = idle_s && gnt_valid_s && gnt_id_s;
   assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // Next-state and datapath update for the IDLE/EXEC/RESP sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_op_d    = alu_op_q;
      rsp_id_d    = rsp_id_q;
      result_d    = result_q;
      flag_d      = flag_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (gnt_id_s) begin
                  alu_in1_d = req1_a;
                  alu_in2_d = req1_b;
                  alu_op_d  = req1_op;
               end else begin
                  alu_in1_d = req0_a;
                  alu_in2_d = req0_b;
                  alu_op_d  = req0_op;
               end
               rsp_id_d = gnt_id_s;
               cnt_d    = CNT_LOAD;
               busy_d   = 1'b1;
               state_d  = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               result_d    = alu_out;
               flag_d      = alu_flag;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               last_d      = rsp_id_q;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         last_q      <= 1'b1;
         alu_in1_q   <= {WIDTH{1'b0}};
         alu_in2_q   <= {WIDTH{1'b0}};
         alu_op_q    <= 2'd0;
         rsp_id_q    <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         flag_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_op_q    <= alu_op_d;
         rsp_id_q    <= rsp_id_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_in1   = alu_in1_q;
   assign alu_in2   = alu_in2_q;
   assign alu_op    = alu_op_q;
   assign rsp_id    = rsp_id_q;
   assign result    = result_q;
   assign flag      = flag_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one 6-bit ALU between two independent requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode inputs for a fixed latency. It then captures the ALU result and flag and returns them on a shared response channel tagged with the requester ID. It sits between the requester logic and the ALU, in place of a single-client controller.

## Interface

Parameters:
- WIDTH, 6, operand/result width
- ALU_LAT, 1, cycles from operands driven to alu_out/alu_flag valid; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  2  requester 0 opcode, passed through to ALU
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- alu_in1, alu_in2  out  WIDTH  registered ALU operands
- alu_op  out  2  registered ALU opcode
- alu_out  in  WIDTH  ALU result
- alu_flag  in  1  ALU flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- result  out  WIDTH  captured alu_out
- flag  out  1  captured alu_flag
- busy  out  1  high in EXEC or RESP

## Operation

- States: IDLE, EXEC, RESP. Reset: IDLE; alu_in1, alu_in2, alu_op, result, flag, rsp_id, rsp_valid, busy all 0; round-robin pointer last=1, so requester 0 wins first.
- IDLE with exactly one valid: grant that requester. With both valid: grant the requester != last.
- reqN_ready is combinational. It is 1 only in IDLE, only for the granted requester, and only when reset=0. It is never 1 for both requesters.
- Accept (valid&&ready at an edge):
  - latch a, b, op into alu_in1, alu_in2, alu_op
  - latch the ID into rsp_id
  - load the latency counter with ALU_LAT-1
  - go to EXEC
- EXEC: alu_in1, alu_in2, alu_op held stable. The counter decrements each cycle. At the edge where the counter is 0, capture alu_out→result and alu_flag→flag, then go to RESP. alu_out is ignored in all other cycles.
- RESP: rsp_valid=1. rsp_id, result and flag are held until rsp_ready=1. On that handshake: rsp_valid→0, last←rsp_id, go to IDLE.
- alu_in1, alu_in2 and alu_op keep their last values after the op completes. They are not cleared.
- A requester holding valid during EXEC or RESP is not accepted and sees ready=0. It may change or drop valid and operands freely while not accepted. Operands are sampled only at the accept edge.
- No arithmetic is performed in this block. result is a bit-exact copy of alu_out.

## Timing

- Accept at edge k: alu_in1, alu_in2 and alu_op are valid from cycle k+1.
- Capture at edge k+ALU_LAT. rsp_valid is high from cycle k+ALU_LAT+1.
- With rsp_ready held high, rsp_valid lasts one cycle and IDLE is re-entered at edge k+ALU_LAT+1. The next accept is possible at edge k+ALU_LAT+2.
- Peak throughput: one op per ALU_LAT+2 cycles.
- rsp_ready low stalls in RESP indefinitely, with no loss and outputs stable.
- Reset asserted in any state returns the block to IDLE at the next edge with all reset values. The in-flight op is dropped and produces no response. ready=0 during the reset cycle.
- Simultaneous requests alternate strictly while both stay valid: 0,1,0,1…
- A lone requester is granted back-to-back regardless of last.

## Test plan

- Single op, ALU_LAT=1, model ALU = add: req0 a=5 b=3 op=00 accepted at edge 2 (req0_ready=1 that cycle) → alu_in1=5, alu_in2=3 in cycle 3; rsp_valid in cycle 4 with result=8, rsp_id=0.
- Contention: req0 and req1 valid continuously after reset with distinct operands → grants in order 0,1,0,1. Responses carry matching rsp_id and results. Only one ready high per cycle.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, result, flag and rsp_id stable. req1_ready stays 0 although req1_valid=1. Accept occurs only after rsp_ready=1.
- Latency parameter: ALU_LAT=3; model ALU drives a garbage value for 2 cycles, then a=10, b=7, op=01 → 13 with flag=1 on the 3rd cycle → result=13, flag=1. The garbage value is never captured. rsp_valid appears 4 cycles after accept.
- Reset mid-op: assert reset for 1 cycle during EXEC → next cycle busy=0, rsp_valid=0, outputs 0, last=1. No response for the dropped op. A new req1-only request is then accepted normally.
- Lone requester: only req1 valid for 3 ops → all three granted to req1 at the minimum interval.
